rsa_exp_ctrl: RTL and testbench

- Initiator-side controller for the 256-bit Montgomery multiplier used in the RSA datapath.
- Computes M = y^d mod N by right-to-left binary exponentiation, issuing Montgomery products through the multiplier's beg/out_ready handshake.
- Sits between the top-level RSA FSM (which supplies the pre-converted base y·2^256 mod N) and a single shared multiplier instance.

---
 rtl/rsa_pkg.sv | 8 +
 rtl/rsa_exp_ctrl_if.sv | 12 +
 rtl/rsa_exp_ctrl.sv | 88 ++++++++
 tb/tb_rsa_exp_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// rsa_pkg: shared width, controller states and multiplier ready polarity
package rsa_pkg;
  localparam int WIDTH = 256;
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [2:0] {IDLE, CHK, MUL_REQ, MUL_WAIT, SQR_REQ, SQR_WAIT, DONE} state_t;
  localparam logic READY = 1'b0;
  localparam logic PROCESS = 1'b1;
endpackage

// File: rtl/rsa_exp_ctrl_if.sv
// rsa_exp_ctrl_if: handshake bundle between exponent controller and Montgomery multiplier
interface rsa_exp_ctrl_if;
  import rsa_pkg::*;
  logic [WIDTH-1:0] mont_a;
  logic [WIDTH-1:0] mont_b;
  logic [WIDTH-1:0] mont_n;
  logic [WIDTH-1:0] mont_out;
  logic mont_beg;
  logic mont_ready_n;
  modport master(output mont_a, mont_b, mont_n, mont_beg, input mont_out, mont_ready_n);
  modport slave(input mont_a, mont_b, mont_n, mont_beg, output mont_out, mont_ready_n);
endinterface

// File: rtl/rsa_exp_ctrl.sv
// rsa_exp_ctrl: right-to-left binary exponentiation over a shared Montgomery multiplier; RSA_EARLY_EXIT_EN stops once the exponent shifter empties
module rsa_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_result,
  output logic             o_done,
  output logic             o_busy,
  rsa_exp_ctrl_if.master   mont
);
  state_t state, nxt;
  logic [WIDTH-1:0] m, t, d_sh, n_r;
  logic [CW-1:0] cnt;
  logic [7:0] sc;
  logic fin, mul, sqr, wt, hit, fire;
  // next state, multiplier drive and settle decision; ready is only trusted in WAIT states
  always_comb begin
`ifdef RSA_EARLY_EXIT_EN
    fin = cnt == CW'(WIDTH) || d_sh == '0;
`else
    fin = cnt == CW'(WIDTH);
`endif
    mul = state == MUL_REQ || state == MUL_WAIT;
    sqr = state == SQR_REQ || state == SQR_WAIT;
    wt = state == MUL_WAIT || state == SQR_WAIT;
    hit = sc != '0 || mont.mont_ready_n == READY;
    fire = wt && hit && sc == 8'(SETTLE_CYC);
    mont.mont_beg = wt;
    mont.mont_a = mul || sqr ? t : '0;
    mont.mont_b = mul ? m : sqr ? t : '0;
    mont.mont_n = mul || sqr ? n_r : '0;
    nxt = state;
    case (state)
      IDLE:     nxt = i_start ? CHK : IDLE;
      CHK:      nxt = fin ? DONE : d_sh[0] ? MUL_REQ : SQR_REQ;
      MUL_REQ:  nxt = MUL_WAIT;
      MUL_WAIT: nxt = fire ? SQR_REQ : MUL_WAIT;
      SQR_REQ:  nxt = SQR_WAIT;
      SQR_WAIT: nxt = fire ? CHK : SQR_WAIT;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end
  // state register, accumulator/square/exponent datapath and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      m <= '0;
      t <= '0;
      d_sh <= '0;
      n_r <= '0;
      cnt <= '0;
      sc <= '0;
      o_result <= '0;
      o_done <= 1'b0;
      o_busy <= 1'b0;
    end else begin
      state <= nxt;
      o_done <= state == DONE;
      sc <= wt && hit && !fire ? sc + 8'd1 : '0;
      if (state == IDLE && i_start) begin
        m <= WIDTH'(1);
        t <= i_a;
        d_sh <= i_d;
        n_r <= i_n;
        cnt <= '0;
        o_busy <= 1'b1;
      end
      if (state == DONE) begin
        o_result <= m;
        o_busy <= 1'b0;
      end
      if (fire && mul) m <= mont.mont_out;
      if (fire && sqr) begin
        t <= mont.mont_out;
        d_sh <= d_sh >> 1;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// tb_rsa_exp_ctrl: randomized self-checking bench with a behavioural Montgomery multiplier and modexp reference
module tb_rsa_exp_ctrl;
  import rsa_pkg::*;
  localparam int SETTLE = 2;
`ifdef RSA_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  typedef logic [WIDTH-1:0] w_t;
  typedef struct {
    w_t a;
    w_t b;
  } prod_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 1'b0;
  w_t i_a = '0, i_d = '0, i_n = '0;
  w_t o_result;
  logic o_done, o_busy;

  rsa_exp_ctrl_if mif();

  rsa_exp_ctrl #(.SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_a(i_a), .i_d(i_d), .i_n(i_n),
    .o_result(o_result), .o_done(o_done), .o_busy(o_busy), .mont(mif)
  );

  always #5 clk = ~clk;

  function automatic w_t mont(input w_t a, input w_t b, input w_t n);
    logic [WIDTH+1:0] s;
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i]) s = s + {2'b00, b};
      if (s[0]) s = s + {2'b00, n};
      s = s >> 1;
    end
    if (s >= {2'b00, n}) s = s - {2'b00, n};
    return s[WIDTH-1:0];
  endfunction

  function automatic w_t mulmod(input w_t a, input w_t b, input w_t n);
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    p = p % {{WIDTH{1'b0}}, n};
    return p[WIDTH-1:0];
  endfunction

  function automatic w_t modexp(input w_t y, input w_t d, input w_t n);
    w_t r, x;
    r = 1;
    x = y;
    for (int i = 0; i < WIDTH; i++) begin
      if (d[i]) r = mulmod(r, x, n);
      x = mulmod(x, x, n);
    end
    return r;
  endfunction

  function automatic w_t to_mont(input w_t y, input w_t n);
    logic [2*WIDTH-1:0] p;
    p = {y, {WIDTH{1'b0}}} % {{WIDTH{1'b0}}, n};
    return p[WIDTH-1:0];
  endfunction

  function automatic int exp_products(input w_t d);
    int k, sq;
    k = 0;
    sq = EARLY ? 0 : WIDTH;
    for (int i = 0; i < WIDTH; i++) begin
      if (d[i]) begin
        k++;
        if (EARLY) sq = i + 1;
      end
    end
    return k + sq;
  endfunction

  function automatic w_t rnd();
    w_t r;
    for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // multiplier stand-in: ready after a random delay, result valid only SETTLE cycles later
  int mc = 0, rc = 0, rlim = 1;
  always @(posedge clk) begin
    if (!mif.mont_beg) begin
      mc = 0;
      rc = 0;
      mif.mont_ready_n <= PROCESS;
    end else if (mif.mont_ready_n == PROCESS) begin
      if (mc == 0) rlim = $urandom_range(4, 1);
      mc++;
      if (mc >= rlim) begin
        mif.mont_ready_n <= READY;
        mif.mont_out <= mont(mif.mont_a, mif.mont_b, mif.mont_n) + mif.mont_n;
        rc = 0;
      end
    end else begin
      rc++;
      if (rc == SETTLE) mif.mont_out <= mont(mif.mont_a, mif.mont_b, mif.mont_n);
    end
  end

  int checks = 0, fails = 0, prod_cnt = 0, exp_cnt = 0;
  w_t exp_res, cur_n, pa, pb;
  logic prev_beg = 1'b0, active = 1'b0, done_seen = 1'b0;
  prod_t exp_q[$];

  task automatic chk(input string nm, input w_t act, input w_t exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic build(input w_t a, input w_t d, input w_t n);
    w_t m, t;
    m = 1;
    t = a;
    exp_q.delete();
    for (int i = 0; i < WIDTH; i++) begin
      if (EARLY && (d >> i) == '0) break;
      if (d[i]) begin
        exp_q.push_back('{t, m});
        m = mont(t, m, n);
      end
      exp_q.push_back('{t, t});
      t = mont(t, t, n);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (rst) begin
      active = 1'b0;
      prev_beg = 1'b0;
      exp_q.delete();
      return;
    end
    if (i_start && !active) begin
      active = 1'b1;
      prod_cnt = 0;
      cur_n = i_n;
      build(i_a, i_d, i_n);
    end
    if (mif.mont_beg && !prev_beg) begin
      prod_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL extra_product: got product %0d want none", prod_cnt);
      end else begin
        prod_t p;
        p = exp_q.pop_front();
        chk("mont_a", mif.mont_a, p.a);
        chk("mont_b", mif.mont_b, p.b);
        chk("mont_n", mif.mont_n, cur_n);
      end
    end else if (mif.mont_beg) begin
      chk("stable_a", mif.mont_a, pa);
      chk("stable_b", mif.mont_b, pb);
    end
    if (o_done) begin
      chk("done_when_active", active, 1);
      chk("result", o_result, exp_res);
      chk("products", prod_cnt, exp_cnt);
      chk("queue_left", exp_q.size(), 0);
      chk("busy_at_done", o_busy, 0);
      active = 1'b0;
      done_seen = 1'b1;
    end else begin
      chk("busy", o_busy, active);
    end
    prev_beg = mif.mont_beg;
    pa = mif.mont_a;
    pb = mif.mont_b;
  endtask

  task automatic run(input w_t a, input w_t d, input w_t n, input w_t res, input int pc);
    exp_res = res;
    exp_cnt = pc;
    done_seen = 1'b0;
    i_a = a;
    i_d = d;
    i_n = n;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 20000 && !done_seen; k++) begin
      if (k == 2 && pc >= 3) begin
        i_a = 1;
        i_d = 3;
        i_start = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      step();
    end
    i_start = 1'b0;
    if (!done_seen) begin
      checks++;
      fails++;
      $display("FAIL timeout: got no o_done want done within 20000 cycles");
    end
  endtask

  initial begin
    w_t n, y, d;
    repeat (3) step();
    chk("rst_result", o_result, 0);
    chk("rst_done", o_done, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_beg", mif.mont_beg, 0);
    chk("rst_a", mif.mont_a, 0);
    chk("rst_b", mif.mont_b, 0);
    chk("rst_n", mif.mont_n, 0);
    chk("pin_mont", mont(6, 6, 13), 12);
    chk("pin_to_mont", to_mont(2, 13), 6);
    chk("pin_modexp5", modexp(2, 5, 13), 6);
    chk("pin_modexp_all", modexp(2, '1, 13), 8);
    i_start = 1'b1;
    i_a = 6;
    i_d = 5;
    i_n = 13;
    step();
    rst = 1'b0;
    i_start = 1'b0;
    step();
    chk("start_with_rst", o_busy, 0);
    run(6, 5, 13, 6, EARLY ? 5 : 258);
    run(6, 0, 13, 1, EARLY ? 0 : 256);
    run(6, 1, 13, 2, EARLY ? 2 : 257);
    run(6, '1, 13, 8, 512);
    exp_res = 8;
    exp_cnt = 512;
    i_a = 6;
    i_d = '1;
    i_n = 13;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 20000 && prod_cnt < 200; k++) step();
    if (prod_cnt < 200) begin
      checks++;
      fails++;
      $display("FAIL midrun_timeout: got %0d products want 200", prod_cnt);
    end
    rst = 1'b1;
    step();
    chk("abort_beg", mif.mont_beg, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_done", o_done, 0);
    rst = 1'b0;
    step();
    run(6, 5, 13, 6, EARLY ? 5 : 258);
    for (int r = 0; r < 3; r++) begin
      n = rnd();
      n[0] = 1'b1;
      n[WIDTH-1] = 1'b1;
      y = rnd() % n;
      d = rnd();
      if (r == 1) d = d >> 200;
      run(to_mont(y, n), d, n, modexp(y, d, n), exp_products(d));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
